// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide, fixed 33-cycle latency, one result bit per CALC cycle.
module muldiv_unit #(
  parameter int BIT_WIDTH  = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [BIT_WIDTH-1:0]  rs1_data,
  input  logic [BIT_WIDTH-1:0]  rs2_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic [BIT_WIDTH-1:0]  result,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  wr_en
);
  localparam int W = BIT_WIDTH;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d, rd_out_q, rd_out_d;
  logic                  a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [W-1:0]          hi_q, hi_d, lo_q, lo_d, mc_q, mc_d, result_q, result_d;
  logic                  is_div, a_neg, b_neg;
  logic [W-1:0]          a_mag, b_mag, hi_n, lo_n, q_s, r_s;
  logic [W:0]            msum, rsh, diff;
  logic [2*W-1:0]        prod;
  // Multiply: hi:lo is the product shifting right, mc the multiplicand.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in, mc the divisor.
  always_comb begin
    is_div = op[2];
    a_neg  = rs1_data[W-1] & (is_div ? ~op[0] : (op[1:0] != 2'b11));
    b_neg  = rs2_data[W-1] & (is_div ? ~op[0] : ~op[1]);
    a_mag  = a_neg ? -rs1_data : rs1_data;
    b_mag  = b_neg ? -rs2_data : rs2_data;
    msum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mc_q : {W{1'b0}})};
    rsh    = {hi_q, lo_q[W-1]};
    diff   = rsh - {1'b0, mc_q};
    hi_n   = op_q[2] ? (diff[W] ? rsh[W-1:0] : diff[W-1:0]) : msum[W:1];
    lo_n   = op_q[2] ? {lo_q[W-2:0], ~diff[W]} : {msum[0], lo_q[W-1:1]};
    prod   = (a_neg_q ^ b_neg_q) ? -{hi_n, lo_n} : {hi_n, lo_n};
    q_s    = ((a_neg_q ^ b_neg_q) && mc_q != '0) ? -lo_n : lo_n;
    r_s    = a_neg_q ? -hi_n : hi_n;
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mc_d     = mc_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    if (state_q == IDLE && start) begin
      state_d = CALC;
      cnt_d   = '0;
      op_d    = op;
      rd_d    = rd_addr;
      a_neg_d = a_neg;
      b_neg_d = b_neg;
      hi_d    = '0;
      lo_d    = is_div ? a_mag : b_mag;
      mc_d    = is_div ? b_mag : a_mag;
    end else if (state_q == CALC) begin
      hi_d  = hi_n;
      lo_d  = lo_n;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'(W-1)) begin
        state_d  = DONE;
        rd_out_d = rd_q;
        result_d = op_q[2] ? (op_q[1] ? r_s : q_s)
                 : (op_q[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W]);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mc_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mc_q     <= mc_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign result = result_q;
  assign rd_out = rd_out_q;
  assign wr_en  = done && rd_out_q != '0;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue checked by an independent done monitor.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic [3:0]  rd_addr = '0;
  logic        busy, done, wr_en;
  logic [31:0] result;
  logic [3:0]  rd_out;

  muldiv_unit #(.BIT_WIDTH(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .rd_addr(rd_addr), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] res; logic [3:0] rd; int acc;} exp_t;
  exp_t sbq[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Done is observed on the falling edge, i.e. the value the 33rd rising edge after accept samples.
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 rd_out=%0d result=%h expected no done", rd_out, result);
      end else begin
        e = sbq.pop_front();
        check("result", result, e.res);
        check("rd_out", {28'd0, rd_out}, {28'd0, e.rd});
        check("wr_en", {31'd0, wr_en}, {31'd0, e.rd != 4'd0});
        check("busy_in_done", {31'd0, busy}, 32'd1);
        check("latency", cyc - e.acc, 32);
      end
    end else if (wr_en) begin
      total++;
      bad++;
      $display("FAIL wr_en_without_done: got wr_en=1 expected 0");
    end
  end

  // Called on a falling edge; returns on the falling edge right after the accepting rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd, input logic [31:0] res);
    op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    sbq.push_back('{res: res, rd: rd, acc: cyc + 1});
    @(negedge clk);
    start = 1'b0; op = ~o; rs1_data = ~a; rs2_data = b + 32'd3; rd_addr = ~rd;
  endtask

  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy) nbusy++;
      if (done) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL done_timeout: got no done in 60 cycles expected done");
  endtask

  logic [2:0]  v_op [12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                             3'b101, 3'b111, 3'b101, 3'b110, 3'b100, 3'b110};
  logic [31:0] v_a  [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd100, 32'd100, 32'd10, 32'd10, 32'h80000000, 32'h80000000};
  logic [31:0] v_b  [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] v_r  [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'd14, 32'd2, 32'hFFFFFFFF, 32'd10, 32'h80000000, 32'd0};

  initial begin
    int nb;
    start = 1'b1; op = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9; rd_addr = 4'd1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", {28'd0, rd_out}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      issue(v_op[i], v_a[i], v_b[i], 4'(i + 5 > 15 ? i - 10 : i + 5), v_r[i]);
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_done(nb);
      check("busy_cycles", nb, 33);
      @(negedge clk);
    end
    issue(3'b000, 32'd6, 32'd7, 4'd13, 32'd42);
    repeat (4) @(negedge clk);
    op = 3'b101; rs1_data = 32'd1; rs2_data = 32'd1; rd_addr = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    repeat (2) @(negedge clk);
    check("ignored_start_idle", {31'd0, busy}, 32'd0);
    issue(3'b000, 32'd3, 32'd4, 4'd0, 32'd12);
    wait_done(nb);
    @(negedge clk);
    issue(3'b000, 32'd5, 32'd5, 4'd14, 32'd25);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(nb);
    repeat (3) @(negedge clk);
    check("hold_result", result, 32'd25);
    check("hold_rd_out", {28'd0, rd_out}, 32'd14);
    issue(3'b101, 32'd50, 32'd5, 4'd15, 32'd10);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(3'b100, 32'd20, 32'hFFFFFFFC, 4'd3, 32'hFFFFFFFB);
    check("post_rst_accept", {31'd0, busy}, 32'd1);
    wait_done(nb);
    repeat (2) @(negedge clk);
    check("queue_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 32: operand and result width in bits.
REQ-002 The block SHALL have parameter REG_ADDR_W, default 4: destination address width, covering the 16 RV32E registers.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have the following control and data ports:
- start  input  1  request a new operation.
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  BIT_WIDTH  operand A, taken from the register file read port 1.
- rs2_data  input  BIT_WIDTH  operand B, taken from the register file read port 2.
- rd_addr  input  REG_ADDR_W  destination register.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle completion pulse.
- result  output  BIT_WIDTH  final value, feeding the register file write data.
- rd_out  output  REG_ADDR_W  destination register for result.
- wr_en  output  1  register file write strobe.

Function
REQ-005 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-006 The FSM SHALL move IDLE->CALC on a start accept, CALC->DONE after 32 CALC cycles, and DONE->IDLE unconditionally.
REQ-007 A start SHALL be accepted only when it is sampled high at a rising edge while the state is IDLE.
REQ-008 A start sampled in CALC or DONE SHALL be ignored, neither queued nor restarted.
REQ-009 On accept, the block SHALL latch op, rs1_data, rs2_data and rd_addr; input changes after accept SHALL NOT affect the operation.
REQ-010 busy SHALL be high exactly when the state is not IDLE.
REQ-011 A 6-bit iteration counter SHALL clear on accept and increment once per CALC cycle; the FSM SHALL leave CALC when the count reaches 31.
REQ-012 Multiply SHALL use a 1-bit-per-cycle shift-add over operand magnitudes, producing a 64-bit product.
REQ-013 The multiply sign SHALL be applied at the end: MUL/MULH treat both operands as signed, MULHSU treats A signed and B unsigned, MULHU treats both unsigned.
REQ-014 MUL SHALL return product bits [31:0]; MULH, MULHSU and MULHU SHALL return bits [63:32].
REQ-015 Divide SHALL use a 1-bit-per-cycle restoring algorithm over magnitudes.
REQ-016 DIV/REM SHALL be signed with quotient truncating toward zero, the remainder taking the sign of the dividend.
REQ-017 DIVU/REMU SHALL be unsigned.
REQ-018 Divide by zero SHALL give a quotient of all ones and a remainder equal to the dividend, with no trap.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give DIV = 0x80000000 and REM = 0.
REQ-020 Latency SHALL be fixed at 33 cycles for every op, including the zero-divisor and overflow cases; there SHALL be no early termination.
REQ-021 done SHALL be high for exactly the one cycle in state DONE, 33 rising edges after the accepting edge.
REQ-022 result and rd_out SHALL be valid during DONE, then hold that value until the next DONE.
REQ-023 wr_en SHALL equal done AND (rd_out != 0); an x0 destination SHALL pulse done without asserting wr_en.
REQ-024 Back-to-back throughput SHALL be one operation per 34 cycles, since a start in the cycle after DONE is accepted.

Reset
REQ-025 While rst is high at a rising edge, the block SHALL go to IDLE, with busy=0, done=0, wr_en=0, result=0, rd_out=0, counter=0 and all datapath registers cleared.
REQ-026 rst SHALL take priority over start in the same cycle.
REQ-027 A reset during CALC or DONE SHALL abandon the operation: no done and no wr_en may follow it.
REQ-028 After rst deasserts, the block SHALL accept a start at the very next edge.

Verification
REQ-029 The bench SHALL cover MUL 7 x 0xFFFFFFFD with rd_addr=5 -> busy for 33 cycles, then done=1, wr_en=1, rd_out=5, result=0xFFFFFFEB.
REQ-030 The bench SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 The bench SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-032 The bench SHALL cover DIVU 10 / 0 -> 0xFFFFFFFF; REM 10 / 0 -> 10; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; each with done still exactly 33 cycles after accept.
REQ-033 The bench SHALL cover a second start with different operands at CALC cycle 5 -> ignored, first result unchanged; then rst at CALC cycle 10 -> busy=0 next cycle, no done pulse.
REQ-034 The bench SHALL cover MUL 3 x 4 with rd_addr=0 -> done=1, result=12, wr_en=0; a start in the following cycle -> accepted, busy=1.
